// File: rtl/demux1to4096_wr_n.sv
// demux1to4096_wr_n: write side of the 4096-entry register bank.
// One n-bit write per cycle comes in over a valid/ready handshake and is
// registered in stage 1. In stage 2 the address is decoded to a one-hot
// enable and the word is stored in the addressed entry. The full bank drives
// data_o, which feeds the mux4096to1_n read path. A clear sweep zeroes one
// entry per cycle and does not need a reset.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   wr_valid_i / wr_ready_o  write handshake
//   wr_addr_i, wr_data_i     write target entry and write data
//   clr_i                    start a clear sweep (sampled only in IDLE)
//   busy_o                   a clear sweep is in progress
//   clr_done_o               one-cycle pulse after the last entry is zeroed
//   data_o                   registered bank, entry i at data_o[i]

// One bank entry. Clear takes priority over write.
module demux1to4096_wr_n_entry #(
  parameter int n = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         we_i,
  input  logic [n-1:0] d_i,
  output logic [n-1:0] q_o
);
  logic [n-1:0] q_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    q_q <= '0;
    else if (clr_i) q_q <= '0;
    else if (we_i)  q_q <= d_i;
  end

  assign q_o = q_q;
endmodule

module demux1to4096_wr_n #(
  parameter int n       = 4,
  parameter int address = 12
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              wr_valid_i,
  output logic                              wr_ready_o,
  input  logic [address-1:0]                wr_addr_i,
  input  logic [n-1:0]                      wr_data_i,
  input  logic                              clr_i,
  output logic                              busy_o,
  output logic                              clr_done_o,
  output logic [(2**address)-1:0][n-1:0]    data_o
);
  localparam int m = 2**address;

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [address-1:0] cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               s1_vld_q;
  logic [address-1:0] s1_addr_q;
  logic [n-1:0]       s1_data_q;
  logic               hs;
  logic [m-1:0]       wr_oh, clr_oh;

  assign wr_ready_o = (state_q == IDLE) & ~clr_i;
  assign hs         = wr_valid_i & wr_ready_o;
  assign busy_o     = (state_q == CLEAR);
  assign clr_done_o = done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_i) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        // Last entry is zeroed at this edge; the done pulse is registered so
        // it shows in the first IDLE cycle, alongside busy_o dropping.
        if (&cnt_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Stage 1. A write accepted the cycle before CLEAR still commits: the
  // handshake is blocked only while clr_i is high or in CLEAR, so stage 1
  // is never valid during the sweep itself.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_vld_q  <= 1'b0;
      s1_addr_q <= '0;
      s1_data_q <= '0;
    end else begin
      s1_vld_q <= hs;
      if (hs) begin
        s1_addr_q <= wr_addr_i;
        s1_data_q <= wr_data_i;
      end
    end
  end

  // Stage 2 decode: one-hot write and clear enables.
  always_comb begin
    wr_oh  = '0;
    clr_oh = '0;
    if (s1_vld_q)          wr_oh[s1_addr_q] = 1'b1;
    if (state_q == CLEAR)  clr_oh[cnt_q]    = 1'b1;
  end

  for (genvar gi = 0; gi < m; gi++) begin : g_entry
    demux1to4096_wr_n_entry #(.n(n)) u_entry (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (clr_oh[gi]),
      .we_i   (wr_oh[gi]),
      .d_i    (s1_data_q),
      .q_o    (data_o[gi])
    );
  end
endmodule

// File: tb/tb_demux1to4096_wr_n.sv
module tb_demux1to4096_wr_n;
  localparam int N = 4;
  localparam int A = 12;
  localparam int M = 4096;

  logic                clk_i = 1'b0;
  logic                rst_ni = 1'b0;
  logic                wr_valid_i = 1'b0;
  logic                wr_ready_o;
  logic [A-1:0]        wr_addr_i = '0;
  logic [N-1:0]        wr_data_i = '0;
  logic                clr_i = 1'b0;
  logic                busy_o;
  logic                clr_done_o;
  logic [M-1:0][N-1:0] data_o;

  // Reference bank: updated from the write/clear rules, not from RTL state.
  logic [M-1:0][N-1:0] exp_bank = '0;
  int pass_cnt = 0;
  int total_cnt = 0;

  demux1to4096_wr_n dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .wr_valid_i(wr_valid_i),
    .wr_ready_o(wr_ready_o), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .clr_i(clr_i), .busy_o(busy_o), .clr_done_o(clr_done_o), .data_o(data_o)
  );

  always #5 clk_i = ~clk_i;

  // Locates the first differing entry, only to make a bank FAIL line readable.
  function automatic int first_diff();
    for (int i = 0; i < M; i++) if (data_o[i] !== exp_bank[i]) return i;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    #12;
    total_cnt++;
    if (data_o !== exp_bank) $display("FAIL reset_bank: entry %0d got %h want %h", first_diff(), data_o[first_diff()], exp_bank[first_diff()]);
    else pass_cnt++;
    total_cnt++;
    if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_o); else pass_cnt++;
    total_cnt++;
    if (clr_done_o !== 1'b0) $display("FAIL reset_done: got %b want 0", clr_done_o); else pass_cnt++;
    total_cnt++;
    if (wr_ready_o !== 1'b1) $display("FAIL reset_ready: got %b want 1", wr_ready_o); else pass_cnt++;
    @(negedge clk_i); rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    wr_valid_i = 1'b1; wr_addr_i = 12'h005; wr_data_i = 4'hA;
    tick();
    wr_valid_i = 1'b0;
    total_cnt++;
    if (data_o[5] !== 4'h0) $display("FAIL single_latency: got %h want 0", data_o[5]); else pass_cnt++;
    tick();
    exp_bank[5] = 4'hA;
    total_cnt++;
    if (data_o !== exp_bank) $display("FAIL single_bank: entry %0d got %h want %h", first_diff(), data_o[first_diff()], exp_bank[first_diff()]);
    else pass_cnt++;
  endtask

  task automatic test_streaming();
    int ready_bad = 0;
    for (int i = 0; i < 16; i++) begin
      wr_valid_i = 1'b1; wr_addr_i = A'(i); wr_data_i = N'(i & 15);
      #1;
      if (wr_ready_o !== 1'b1) ready_bad++;
      tick();
    end
    wr_valid_i = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) exp_bank[i] = N'(i & 15);
    total_cnt++;
    if (ready_bad != 0) $display("FAIL stream_ready: got %0d stalled cycles want 0", ready_bad); else pass_cnt++;
    total_cnt++;
    if (data_o !== exp_bank) $display("FAIL stream_bank: entry %0d got %h want %h", first_diff(), data_o[first_diff()], exp_bank[first_diff()]);
    else pass_cnt++;
    total_cnt++;
    if (data_o[M-1] !== 4'h0) $display("FAIL stream_top_entry: got %h want 0", data_o[M-1]); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    wr_valid_i = 1'b1; wr_addr_i = 12'h123; wr_data_i = 4'h3;
    tick();
    wr_data_i = 4'hC;
    tick();
    wr_valid_i = 1'b0;
    total_cnt++;
    if (data_o[12'h123] !== 4'h3) $display("FAIL collide_first: got %h want 3", data_o[12'h123]); else pass_cnt++;
    tick();
    exp_bank[12'h123] = 4'hC;
    total_cnt++;
    if (data_o !== exp_bank) $display("FAIL collide_bank: entry %0d got %h want %h", first_diff(), data_o[first_diff()], exp_bank[first_diff()]);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic         pv = 1'b0;
    logic [A-1:0] pa = '0;
    logic [N-1:0] pd = '0;
    int bad = 0;
    for (int c = 0; c < 300; c++) begin
      wr_valid_i = 1'($urandom_range(0, 1));
      wr_addr_i  = A'($urandom_range(0, 31));
      wr_data_i  = N'($urandom);
      tick();
      if (pv) exp_bank[pa] = pd;
      pv = wr_valid_i; pa = wr_addr_i; pd = wr_data_i;
      total_cnt++;
      if (data_o !== exp_bank) begin
        bad++;
        if (bad < 4) $display("FAIL random_bank: cycle %0d entry %0d got %h want %h", c, first_diff(), data_o[first_diff()], exp_bank[first_diff()]);
      end else pass_cnt++;
    end
    wr_valid_i = 1'b0;
    tick();
    if (pv) exp_bank[pa] = pd;
    total_cnt++;
    if (data_o !== exp_bank) $display("FAIL random_final: entry %0d got %h want %h", first_diff(), data_o[first_diff()], exp_bank[first_diff()]);
    else pass_cnt++;
  endtask

  task automatic test_clear();
    int busy_cyc = 0, done_cnt = 0, ready_bad = 0, c = 0;
    // Fill every entry back-to-back so the last write is still in stage 1
    // when the sweep starts.
    for (int i = 0; i < M; i++) begin
      wr_valid_i = 1'b1; wr_addr_i = A'(i); wr_data_i = 4'hF;
      tick();
    end
    // Write and clr_i together: no handshake, sweep starts.
    wr_addr_i = 12'h00A; wr_data_i = 4'h5; clr_i = 1'b1;
    #1;
    total_cnt++;
    if (wr_ready_o !== 1'b0) $display("FAIL clr_same_cycle_ready: got %b want 0", wr_ready_o); else pass_cnt++;
    tick();
    clr_i = 1'b0;
    total_cnt++;
    if (clr_done_o !== 1'b0) $display("FAIL clr_early_done: got %b want 0", clr_done_o); else pass_cnt++;
    while (busy_o === 1'b1 && c < 5000) begin
      busy_cyc++;
      if (wr_ready_o !== 1'b0) ready_bad++;
      if (c == 8) begin
        total_cnt++;
        if (data_o[7] !== 4'h0 || data_o[8] !== 4'hF || data_o[M-1] !== 4'hF)
          $display("FAIL clr_progress: e7=%h e8=%h eTop=%h want 0 f f", data_o[7], data_o[8], data_o[M-1]);
        else pass_cnt++;
      end
      tick();
      c++;
      if (clr_done_o === 1'b1) done_cnt++;
    end
    total_cnt++;
    if (busy_cyc != M) $display("FAIL clr_busy_len: got %0d want %0d", busy_cyc, M); else pass_cnt++;
    total_cnt++;
    if (ready_bad != 0) $display("FAIL clr_ready_low: got %0d ready cycles want 0", ready_bad); else pass_cnt++;
    total_cnt++;
    if (done_cnt != 1 || clr_done_o !== 1'b1) $display("FAIL clr_done_pulse: got %0d pulses, now %b want 1, 1", done_cnt, clr_done_o);
    else pass_cnt++;
    total_cnt++;
    if (wr_ready_o !== 1'b1) $display("FAIL clr_ready_after: got %b want 1", wr_ready_o); else pass_cnt++;
    exp_bank = '0;
    total_cnt++;
    if (data_o !== exp_bank) $display("FAIL clr_bank_zero: entry %0d got %h want %h", first_diff(), data_o[first_diff()], exp_bank[first_diff()]);
    else pass_cnt++;
    // The held write is accepted now that the sweep is over.
    tick();
    wr_valid_i = 1'b0;
    total_cnt++;
    if (clr_done_o !== 1'b0) $display("FAIL clr_done_single: got %b want 0", clr_done_o); else pass_cnt++;
    tick();
    exp_bank[12'h00A] = 4'h5;
    total_cnt++;
    if (data_o !== exp_bank) $display("FAIL clr_held_write: entry %0d got %h want %h", first_diff(), data_o[first_diff()], exp_bank[first_diff()]);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_sweep();
    int done_cnt = 0, busy_cnt = 0;
    for (int i = 8; i < 16; i++) begin
      wr_valid_i = 1'b1; wr_addr_i = A'(i); wr_data_i = 4'hF;
      tick();
    end
    wr_valid_i = 1'b0; clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    for (int i = 8; i < 16; i++) exp_bank[i] = 4'hF;
    repeat (7) tick();
    total_cnt++;
    if (data_o[15] !== 4'hF || data_o[8] !== 4'hF || busy_o !== 1'b1)
      $display("FAIL midsweep_pre: e8=%h e15=%h busy=%b want f f 1", data_o[8], data_o[15], busy_o);
    else pass_cnt++;
    rst_ni = 1'b0;
    #1;
    exp_bank = '0;
    total_cnt++;
    if (data_o !== exp_bank) $display("FAIL midsweep_bank: entry %0d got %h want %h", first_diff(), data_o[first_diff()], exp_bank[first_diff()]);
    else pass_cnt++;
    total_cnt++;
    if (busy_o !== 1'b0 || clr_done_o !== 1'b0) $display("FAIL midsweep_flags: busy=%b done=%b want 0 0", busy_o, clr_done_o);
    else pass_cnt++;
    #3 rst_ni = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (clr_done_o !== 1'b0) done_cnt++;
      if (busy_o !== 1'b0) busy_cnt++;
    end
    total_cnt++;
    if (done_cnt != 0 || busy_cnt != 0) $display("FAIL midsweep_after: done=%0d busy=%0d cycles want 0 0", done_cnt, busy_cnt);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_streaming();
    test_back_to_back();
    test_random();
    test_clear();
    test_reset_mid_sweep();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/demux1to4096_wr_n.md
# demux1to4096_wr_n

Write-side counterpart of the 4096:1 read mux: accepts one n-bit write per cycle over a valid/ready handshake, decodes the 12-bit address to a one-hot write enable and stores the word into a 4096-entry register bank whose full contents drive `data_o`. The bank feeds the mux4096to1_n read path directly. A sequential clear sweep zeroes the bank on request without a reset.

## Interface
- `n`, 4, data word width
- `address`, 12, address width
- `m`, 2**address, number of bank entries (derived, not overridden)

- `clk_i`  in  1  clock; all state changes on rising edge
- `rst_ni`  in  1  reset; asynchronous, active-low
- `wr_valid_i`  in  1  write request valid
- `wr_ready_o`  out  1  block can accept a write this cycle
- `wr_addr_i`  in  address  target entry index
- `wr_data_i`  in  n  write data
- `clr_i`  in  1  start clear sweep (sampled only in IDLE)
- `busy_o`  out  1  clear sweep in progress
- `clr_done_o`  out  1  one-cycle pulse when the sweep finishes
- `data_o`  out  n × [0:m-1]  registered bank contents, entry i at `data_o[i]`

## Operation
- FSM states: IDLE, CLEAR.
- Write pipeline: stage 1 registers {valid, addr, data} on handshake (`wr_valid_i & wr_ready_o`); stage 2 decodes addr to one-hot and writes `data_o[addr]`.
- IDLE -> CLEAR when `clr_i`=1 in IDLE; sweep counter loads 0.
- CLEAR: each cycle writes 0 to `data_o[cnt]`, cnt increments; on cycle with cnt=m-1 the zero is written, `clr_done_o` pulses, and the next state is IDLE. Exactly m cycles in CLEAR.
- `wr_ready_o` = (state==IDLE) & ~`clr_i`; writes stall during the sweep and in the cycle `clr_i` is asserted.
- A write accepted in the cycle before CLEAR is entered is still committed from stage 1; the sweep runs afterwards and zeroes it if reached.
- `clr_i` in CLEAR is ignored (no restart, no extension).
- `busy_o` = (state==CLEAR).
- Back-to-back writes to the same address: later write wins; writes to distinct addresses each land exactly one entry; all other entries hold.
- `wr_addr_i`/`wr_data_i` are don't-care when no handshake occurs; no entry changes.
- No read path inside the block; consumers select through the mux.

## Timing
- Reset (`rst_ni`=0, any time, asynchronous): all `data_o` entries 0, stage-1 valid 0, state IDLE, cnt 0, `busy_o`=0, `clr_done_o`=0; `wr_ready_o`=1 when `clr_i`=0.
- Reset mid-write: pending stage-1 write discarded. Reset mid-sweep: sweep aborted, bank fully zero, IDLE.
- Write latency: handshake at edge k -> `data_o[addr]` shows new data after edge k+1.
- Throughput: one write per cycle in IDLE.
- `clr_i` high at edge k (IDLE) -> `busy_o`=1 after edge k, entry i zeroed after edge k+1+i, `clr_done_o` high for the cycle after edge k+m, `busy_o`=0 and `wr_ready_o`=1 (given `clr_i`=0) after edge k+m.
- Stage-1 write accepted at edge k-1 commits at edge k, same edge that enters CLEAR.

## Test plan
- Reset then single write: addr=0x005, data=0xA, valid for 1 cycle -> `data_o[5]`=0xA one cycle after handshake, all other entries 0.
- Streaming writes: addr 0..15 with data=addr&0xF on consecutive cycles -> `wr_ready_o` stays 1, each `data_o[i]`=i&0xF, entry 0xFFF untouched (0).
- Same-address collision: 0x123<-0x3 then 0x123<-0xC back-to-back -> final `data_o[0x123]`=0xC.
- Clear sweep (address=4, m=16): fill all entries with 0xF, pulse `clr_i` -> `busy_o` high exactly 16 cycles, `wr_ready_o` low throughout, `clr_done_o` single pulse, all entries 0; `wr_valid_i` held during sweep causes no write.
- Write with `clr_i` same cycle: `wr_valid_i`=1, `clr_i`=1 in IDLE -> no handshake (`wr_ready_o`=0), sweep starts; write then accepted after `busy_o` drops.
- Async reset mid-sweep at cnt=7 with entries 8..15=0xF -> immediately all entries 0, `busy_o`=0, no `clr_done_o` pulse.
